// File: rtl/ysyx_25020037_icache_2way.sv
// ysyx_25020037_icache_2way
// Two-way set-associative instruction cache with multi-word lines, burst
// refill on miss, one LRU bit per set and an invalidate-all (fence.i) port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cpu_req, cpu_addr   fetch request (level) and word-aligned address, taken in IDLE
//   cpu_data, cpu_ready one-cycle response pulse with the instruction word
//   cpu_hit             high with cpu_ready when the response came from a hit
//   flush, flush_done   invalidate-all request (level) and its one-cycle acknowledge
//   mem_req, mem_addr   burst read request with line-aligned base address
//   mem_len             beats-1 of the burst, driven while mem_req is high
//   mem_rvalid, mem_rdata  read beats from the instruction memory bus
//   hit_cnt, miss_cnt   free-running wrap-around performance counters
//
// Handshake: a request is accepted on any clock edge in IDLE with cpu_req high
// (flush has priority); the response is the single cycle with cpu_ready high.
// Refill beats are accepted on every edge in REFILL with mem_rvalid high.
module ysyx_25020037_icache_2way #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_ready,
    output logic                  cpu_hit,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_len,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
);
    localparam int BOFF = $clog2(DATA_WIDTH / 8);
    localparam int WOFF = $clog2(LINE_WORDS);
    localparam int OFF  = BOFF + WOFF;
    localparam int IDX  = $clog2(SETS);
    localparam int TAG  = ADDR_WIDTH - IDX - OFF;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [TAG-1:0]        tag_q   [2][SETS];
    logic [1:0]            valid_q [SETS];
    logic [SETS-1:0]       lru_q;            // way to evict next, per set
    logic [DATA_WIDTH-1:0] data_q  [2][SETS][LINE_WORDS];
    logic [WOFF-1:0]       beat_cnt;
    logic                  victim;
    logic [DATA_WIDTH-1:0] fill_word;        // requested word seen during refill

    logic [TAG-1:0]        req_tag;
    logic [IDX-1:0]        req_idx;
    logic [WOFF-1:0]       req_off;
    logic                  hit0;
    logic                  hit1;
    logic [DATA_WIDTH-1:0] hit_word;
    logic                  pick_victim;
    logic                  last_beat;
    logic                  unused_bits;

    assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG];
    assign req_idx   = req_addr[OFF +: IDX];
    assign req_off   = req_addr[BOFF +: WOFF];
    assign last_beat = (beat_cnt == WOFF'(LINE_WORDS - 1));
    // Fetch addresses are word-aligned, so the byte-offset bits carry nothing.
    assign unused_bits = ^req_addr[BOFF-1:0];

    // Burst length is only meaningful alongside mem_req; idle bus reads as zero.
    assign mem_len = mem_req ? 8'(LINE_WORDS - 1) : 8'd0;

    always_comb begin
        hit0        = valid_q[req_idx][0] && (tag_q[0][req_idx] == req_tag);
        hit1        = valid_q[req_idx][1] && (tag_q[1][req_idx] == req_tag);
        hit_word    = hit1 ? data_q[1][req_idx][req_off] : data_q[0][req_idx][req_off];
        // Fill an empty way first (way0 before way1), otherwise evict the LRU way.
        pick_victim = 1'b0;
        if (!valid_q[req_idx][0])
            pick_victim = 1'b0;
        else if (!valid_q[req_idx][1])
            pick_victim = 1'b1;
        else
            pick_victim = lru_q[req_idx];
    end

    // Line data needs no reset: a line is unreachable until its valid bit is set.
    always_ff @(posedge clk) begin
        if (state == REFILL && mem_rvalid)
            data_q[victim][req_idx][beat_cnt] <= mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_addr   <= '0;
            lru_q      <= '0;
            beat_cnt   <= '0;
            victim     <= 1'b0;
            fill_word  <= '0;
            cpu_data   <= '0;
            cpu_ready  <= 1'b0;
            cpu_hit    <= 1'b0;
            flush_done <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s]  <= 2'b00;
                tag_q[0][s] <= '0;
                tag_q[1][s] <= '0;
            end
        end else begin
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++)
                            valid_q[s] <= 2'b00;
                        lru_q      <= '0;
                        flush_done <= 1'b1;
                    end else if (cpu_req) begin
                        req_addr <= cpu_addr;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit0 || hit1) begin
                        cpu_data        <= hit_word;
                        cpu_ready       <= 1'b1;
                        cpu_hit         <= 1'b1;
                        // Evict the way that was not just used.
                        lru_q[req_idx]  <= hit0;
                        hit_cnt         <= hit_cnt + 32'd1;
                        state           <= RESP;
                    end else begin
                        miss_cnt <= miss_cnt + 32'd1;
                        victim   <= pick_victim;
                        beat_cnt <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= {req_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == req_off)
                            fill_word <= mem_rdata;
                        if (last_beat) begin
                            // The line becomes valid only once every word is in.
                            tag_q[victim][req_idx]   <= req_tag;
                            valid_q[req_idx][victim] <= 1'b1;
                            lru_q[req_idx]           <= ~victim;
                            mem_req                  <= 1'b0;
                            mem_addr                 <= '0;
                            cpu_data  <= (beat_cnt == req_off) ? mem_rdata : fill_word;
                            cpu_ready <= 1'b1;
                            cpu_hit   <= 1'b0;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    cpu_data  <= '0;
                    cpu_ready <= 1'b0;
                    cpu_hit   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25020037_icache_2way.sv
// Bench for ysyx_25020037_icache_2way: scenario tasks drive fetches and a
// burst memory model; a negedge scoreboard pops the expected word/hit flag
// each time the cache answers.
module tb_ysyx_25020037_icache_2way;
    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_ready;
    logic        cpu_hit;
    logic        flush;
    logic        flush_done;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_len;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] exp_q[$];
    logic        hit_q[$];

    ysyx_25020037_icache_2way dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_data(cpu_data), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit),
        .flush(flush), .flush_done(flush_done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // ---------------- memory model ----------------
    // Line 0x8000_0000 holds 0x11,0x22,0x33,0x44; everything else is address-derived.
    function automatic logic [31:0] model_word(input logic [31:0] a);
        if (a[31:4] == 28'h8000000)
            return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
        return a ^ 32'h5A5A_0000;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (cpu_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: cpu_ready with data=%h but nothing expected", cpu_data);
            end else begin
                logic [31:0] e;
                logic        h;
                e = exp_q.pop_front();
                h = hit_q.pop_front();
                if (cpu_data !== e || cpu_hit !== h) begin
                    errors++;
                    $display("FAIL sb_resp: got data=%h hit=%b, expected data=%h hit=%b",
                             cpu_data, cpu_hit, e, h);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge with mem_req high; returns at the negedge after the response.
    task automatic serve_line(input logic [31:0] base, input int max_gap,
                              output bit stable_ok, output bit done_ok);
        int gap;
        stable_ok = 1'b1;
        for (int b = 0; b < 4; b++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                mem_rvalid = 1'b0;
                @(negedge clk);
                if (mem_req !== 1'b1 || mem_addr !== base) stable_ok = 1'b0;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = model_word(base + 32'(4 * b));
            @(negedge clk);
            if (b < 3 && (mem_req !== 1'b1 || mem_addr !== base)) stable_ok = 1'b0;
        end
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        done_ok = (cpu_ready === 1'b1) && (mem_req === 1'b0);
        @(negedge clk);
        done_ok &= (cpu_ready === 1'b0);
    endtask

    // Called at a negedge with the cache idle; returns at the negedge where it is idle again.
    task automatic fetch(input logic [31:0] addr, input bit exp_hit, input int max_gap,
                         output bit saw_mem, output bit addr_ok, output bit timing_ok);
        logic [31:0] base;
        bit          stable;
        base = addr & 32'hFFFF_FFF0;
        exp_q.push_back(model_word(addr));
        hit_q.push_back(exp_hit);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        saw_mem = (mem_req === 1'b1);
        if (saw_mem) begin
            addr_ok = (mem_addr === base) && (mem_len === 8'd3) && (cpu_ready === 1'b0);
            serve_line(base, max_gap, stable, timing_ok);
            addr_ok &= stable;
        end else begin
            addr_ok   = 1'b1;
            timing_ok = (cpu_ready === 1'b1);
            @(negedge clk);
            timing_ok &= (cpu_ready === 1'b0);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cpu_data, cpu_ready, cpu_hit, flush_done, mem_req, mem_addr, mem_len,
             hit_cnt, miss_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: data=%h rdy=%b hit=%b fd=%b mreq=%b maddr=%h mlen=%h hc=%0d mc=%0d, required all 0",
                     cpu_data, cpu_ready, cpu_hit, flush_done, mem_req, mem_addr, mem_len, hit_cnt, miss_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cold_miss();
        bit m, a, t;
        fetch(32'h8000_0008, 1'b0, 0, m, a, t);
        checks++;
        if (m !== 1'b1) begin errors++; $display("FAIL cold_miss_memreq: mem_req=%b required 1", m); end
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL cold_miss_addr: mem_addr/mem_len ok=%b required 1 (0x80000000, len 3)", a); end
        checks++;
        if (t !== 1'b1) begin errors++; $display("FAIL cold_miss_timing: ok=%b required 1", t); end
        checks++;
        if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
            errors++; $display("FAIL cold_miss_cnt: hit=%0d miss=%0d required 0/1", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_line_hit();
        bit m, a, t;
        fetch(32'h8000_000C, 1'b1, 0, m, a, t);
        checks++;
        if (m !== 1'b0) begin errors++; $display("FAIL line_hit_memreq: mem_req=%b required 0", m); end
        checks++;
        if (t !== 1'b1) begin errors++; $display("FAIL line_hit_latency: ready-at-2 ok=%b required 1", t); end
        checks++;
        if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
            errors++; $display("FAIL line_hit_cnt: hit=%0d miss=%0d required 1/1", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_lru();
        logic [31:0] addrs [5];
        bit          hits  [5];
        bit m, a, t;
        addrs = '{32'h8000_0080, 32'h8000_0000, 32'h8000_0100, 32'h8000_0004, 32'h8000_0084};
        hits  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            fetch(addrs[i], hits[i], 0, m, a, t);
            checks++;
            if (m !== !hits[i] || a !== 1'b1 || t !== 1'b1) begin
                errors++;
                $display("FAIL lru_step%0d: addr=%h mem_req=%b addr_ok=%b timing_ok=%b, required mem_req=%b ok=1/1",
                         i, addrs[i], m, a, t, !hits[i]);
            end
        end
        checks++;
        if (hit_cnt !== 32'd3 || miss_cnt !== 32'd4) begin
            errors++; $display("FAIL lru_cnt: hit=%0d miss=%0d required 3/4", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_flush();
        bit s, d, m, a, t;
        exp_q.push_back(model_word(32'h8000_0000));
        hit_q.push_back(1'b0);
        flush    = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 32'h8000_0000;
        @(negedge clk);
        checks++;
        if (flush_done !== 1'b1 || mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
            errors++; $display("FAIL flush_done: fd=%b mreq=%b rdy=%b required 1/0/0", flush_done, mem_req, cpu_ready);
        end
        flush = 1'b0;
        @(negedge clk);
        cpu_req = 1'b0;
        checks++;
        if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_pulse: fd=%b required 0", flush_done); end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0000) begin
            errors++; $display("FAIL flush_miss: mem_req=%b mem_addr=%h required 1/80000000", mem_req, mem_addr);
        end
        serve_line(32'h8000_0000, 0, s, d);
        checks++;
        if (s !== 1'b1 || d !== 1'b1) begin errors++; $display("FAIL flush_refill: stable=%b done=%b required 1/1", s, d); end
        fetch(32'h8000_0088, 1'b0, 0, m, a, t);
        checks++;
        if (m !== 1'b1 || hit_cnt !== 32'd3 || miss_cnt !== 32'd6) begin
            errors++; $display("FAIL flush_second: mem_req=%b hit=%0d miss=%0d required 1/3/6", m, hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_stalled_bus();
        bit m, a, t;
        logic [31:0] addr;
        for (int i = 0; i < 4; i++) begin
            addr = 32'h8000_1000 + 32'(16 * i) + 32'(4 * $urandom_range(0, 3));
            fetch(addr, 1'b0, 3, m, a, t);
            checks++;
            if (m !== 1'b1 || a !== 1'b1 || t !== 1'b1) begin
                errors++;
                $display("FAIL stall_line%0d: addr=%h mem_req=%b stable=%b ready_after_last=%b required 1/1/1",
                         i, addr, m, a, t);
            end
        end
        checks++;
        if (miss_cnt !== 32'd10) begin errors++; $display("FAIL stall_cnt: miss=%0d required 10", miss_cnt); end
    endtask

    task automatic test_back_to_back();
        bit m, a, t;
        bit all_ok;
        int c0;
        logic [31:0] addr;
        all_ok = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            addr = 32'h8000_1000 + 32'(16 * i) + 32'(4 * $urandom_range(0, 3));
            fetch(addr, 1'b1, 0, m, a, t);
            all_ok &= (m == 1'b0) && t;
        end
        checks++;
        if (all_ok !== 1'b1 || (cyc - c0) != 12) begin
            errors++; $display("FAIL b2b_hits: all_hit=%b cycles=%0d required 1/12", all_ok, cyc - c0);
        end
        checks++;
        if (hit_cnt !== 32'd7) begin errors++; $display("FAIL b2b_cnt: hit=%0d required 7", hit_cnt); end
    endtask

    task automatic test_reset_mid_refill();
        bit m, a, t;
        cpu_req  = 1'b1;
        cpu_addr = 32'h8000_2004;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL midrst_start: mem_req=%b required 1", mem_req); end
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = model_word(32'h8000_2000 + 32'(4 * b));
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({cpu_data, cpu_ready, cpu_hit, flush_done, mem_req, mem_addr, mem_len,
             hit_cnt, miss_cnt} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: mreq=%b maddr=%h mlen=%h rdy=%b hc=%0d mc=%0d, required all 0",
                     mem_req, mem_addr, mem_len, cpu_ready, hit_cnt, miss_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        mem_rvalid = 1'b0;
        checks++;
        if (cpu_ready !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL stray_rvalid: rdy=%b mreq=%b required 0/0", cpu_ready, mem_req);
        end
        fetch(32'h8000_2004, 1'b0, 1, m, a, t);
        checks++;
        if (m !== 1'b1 || a !== 1'b1 || t !== 1'b1 || miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
            errors++;
            $display("FAIL midrst_reread: mem_req=%b addr_ok=%b timing=%b hit=%0d miss=%0d required 1/1/1/0/1",
                     m, a, t, hit_cnt, miss_cnt);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst        = 1'b1;
        cpu_req    = 1'b0;
        cpu_addr   = '0;
        flush      = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(negedge clk);
        test_reset();
        test_cold_miss();
        test_line_hit();
        test_lru();
        test_flush();
        test_stalled_bus();
        test_back_to_back();
        test_reset_mid_refill();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover: %0d responses never arrived, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
